croc_irq_cond: RTL and testbench



---
 rtl/croc_irq_cond_pkg.sv | 7 +
 rtl/croc_irq_cond_if.sv | 24 ++
 rtl/croc_irq_cond_line.sv | 73 +++++++
 rtl/croc_irq_cond.sv | 37 +++
 tb/tb_croc_irq_cond.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/croc_irq_cond_pkg.sv
// Shared constants for the external interrupt conditioner.
package croc_irq_cond_pkg;

    localparam int unsigned NumExternalIrqs = 4;
    localparam int unsigned IrqFilterCycles = 4;

endpackage

// File: rtl/croc_irq_cond_if.sv
// Pin, configuration and output bundle of the interrupt conditioner.
interface croc_irq_cond_if #(
    parameter int unsigned NumIrqs = 4
);

    logic [NumIrqs-1:0] irq_pins_i;
    logic [NumIrqs-1:0] polarity_i;
    logic [NumIrqs-1:0] edge_mode_i;
    logic [NumIrqs-1:0] enable_i;
    logic [NumIrqs-1:0] clear_i;
    logic [NumIrqs-1:0] irq_o;
    logic [NumIrqs-1:0] level_o;

    modport master (
        output irq_pins_i, polarity_i, edge_mode_i, enable_i, clear_i,
        input  irq_o, level_o
    );

    modport slave (
        input  irq_pins_i, polarity_i, edge_mode_i, enable_i, clear_i,
        output irq_o, level_o
    );

endinterface

// File: rtl/croc_irq_cond_line.sv
// One interrupt line: synchroniser, symmetric glitch filter and edge-pending latch.
module croc_irq_cond_line
    import croc_irq_cond_pkg::*;
#(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterCycles = IrqFilterCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    input  logic polarity_i,
    input  logic edge_mode_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic irq_o,
    output logic level_o
);

    localparam int unsigned     CntW    = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic [CntW-1:0]       cnt_q;
    logic                  filt_q;
    logic                  pending_q;
    logic                  raw;
    logic                  update;
    logic                  rise;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pin_i};
        end
    end

    assign raw    = sync_q[SyncStages-1] ^ polarity_i;
    assign update = (raw != filt_q) && (cnt_q == CntLast);
    assign rise   = update && raw;

    // cnt_q counts consecutive disagreeing samples; any agreement restarts it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (raw == filt_q) begin
            cnt_q  <= '0;
        end else if (update) begin
            filt_q <= raw;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + CntW'(1);
        end
    end

    // a rise event outranks a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
        end else if (!edge_mode_i || !enable_i) begin
            pending_q <= 1'b0;
        end else if (rise) begin
            pending_q <= 1'b1;
        end else if (clear_i) begin
            pending_q <= 1'b0;
        end
    end

    assign irq_o   = edge_mode_i ? pending_q : (filt_q & enable_i);
    assign level_o = filt_q;

endmodule

// File: rtl/croc_irq_cond.sv
// External interrupt conditioner: one independent conditioning line per interrupt pin.
module croc_irq_cond
    import croc_irq_cond_pkg::*;
#(
    parameter int unsigned NumIrqs      = NumExternalIrqs,
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterCycles = IrqFilterCycles
) (
    input logic            clk_i,
    input logic            rst_ni,
    croc_irq_cond_if.slave bus
);

    logic [NumIrqs-1:0] irq;
    logic [NumIrqs-1:0] level;

    for (genvar i = 0; i < NumIrqs; i++) begin : gen_line
        croc_irq_cond_line #(
            .SyncStages  (SyncStages),
            .FilterCycles(FilterCycles)
        ) u_line (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .pin_i      (bus.irq_pins_i[i]),
            .polarity_i (bus.polarity_i[i]),
            .edge_mode_i(bus.edge_mode_i[i]),
            .enable_i   (bus.enable_i[i]),
            .clear_i    (bus.clear_i[i]),
            .irq_o      (irq[i]),
            .level_o    (level[i])
        );
    end

    assign bus.irq_o   = irq;
    assign bus.level_o = level;

endmodule

// File: tb/tb_croc_irq_cond.sv
// Self-checking bench for croc_irq_cond: directed table, corner sequences, random vs reference model.
module tb_croc_irq_cond;
    import croc_irq_cond_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned S = 2;
    localparam int unsigned F = IrqFilterCycles;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    croc_irq_cond_if #(.NumIrqs(N)) bus ();

    croc_irq_cond #(
        .NumIrqs     (N),
        .SyncStages  (S),
        .FilterCycles(F)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pin history, post-sync raw history, filtered state, pending.
    logic [63:0]  pin_hist [N];
    logic [63:0]  raw_hist [N];
    logic [N-1:0] filt_m;
    logic [N-1:0] pend_m;

    function automatic void model_reset();
        for (int l = 0; l < N; l++) begin
            pin_hist[l] = '0;
            raw_hist[l] = '0;
        end
        filt_m = '0;
        pend_m = '0;
    endfunction

    // The filtered state flips once the last F raw samples all disagree with it.
    function automatic void model_edge();
        logic [63:0] mask;
        mask = (64'd1 << F) - 64'd1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int l = 0; l < N; l++) begin
            logic raw;
            logic rise;
            raw         = pin_hist[l][S-1] ^ bus.polarity_i[l];
            pin_hist[l] = {pin_hist[l][62:0], bus.irq_pins_i[l]};
            raw_hist[l] = {raw_hist[l][62:0], raw};
            rise        = 1'b0;
            if ((raw_hist[l] & mask) == (filt_m[l] ? 64'd0 : mask)) begin
                rise      = raw;
                filt_m[l] = raw;
            end
            if (!bus.edge_mode_i[l] || !bus.enable_i[l]) pend_m[l] = 1'b0;
            else if (rise)                               pend_m[l] = 1'b1;
            else if (bus.clear_i[l])                     pend_m[l] = 1'b0;
        end
    endfunction

    function automatic logic [N-1:0] exp_irq();
        return (bus.edge_mode_i & pend_m) | (~bus.edge_mode_i & filt_m & bus.enable_i);
    endfunction

    function automatic void check_model(input string name);
        n_cmp++;
        if (bus.level_o !== filt_m || bus.irq_o !== exp_irq()) begin
            n_fail++;
            $display("FAIL %s: level=%b irq=%b, expected level=%b irq=%b",
                     name, bus.level_o, bus.irq_o, filt_m, exp_irq());
        end
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic cycle(input string name);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(name);
    endtask

    // Edges from the first sampling edge until the watched output rises (0 = never).
    task automatic rise_edges(input int line, input bit use_irq, output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle("latency_track");
            if (n == 0 && (use_irq ? bus.irq_o[line] : bus.level_o[line])) n = k;
        end
    endtask

    task automatic pulse_pin(input int line, input int len);
        bus.irq_pins_i[line] = 1'b1;
        repeat (len) cycle("pulse");
        bus.irq_pins_i[line] = 1'b0;
        repeat (8) cycle("pulse_tail");
    endtask

    typedef struct {
        logic [N-1:0] pins;
        logic [N-1:0] pol;
        logic [N-1:0] edm;
        logic [N-1:0] en;
        logic [N-1:0] clr;
        int           hold;
        logic [N-1:0] exp_level;
        logic [N-1:0] exp_irq;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        bit seen;

        tbl[0] = '{4'b0011, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8, 4'b0011, 4'b0011};
        tbl[1] = '{4'b0011, 4'b0101, 4'b0000, 4'b1111, 4'b0000, 8, 4'b0110, 4'b0110};
        tbl[2] = '{4'b0011, 4'b0101, 4'b0000, 4'b0100, 4'b0000, 1, 4'b0110, 4'b0100};
        tbl[3] = '{4'b0011, 4'b0101, 4'b1111, 4'b1111, 4'b0000, 8, 4'b0110, 4'b0000};
        tbl[4] = '{4'b1100, 4'b0101, 4'b1111, 4'b1111, 4'b0000, 8, 4'b1001, 4'b1001};
        tbl[5] = '{4'b1100, 4'b0101, 4'b1111, 4'b1111, 4'b0001, 1, 4'b1001, 4'b1000};
        tbl[6] = '{4'b0000, 4'b0101, 4'b1111, 4'b1111, 4'b0000, 8, 4'b0101, 4'b1100};
        tbl[7] = '{4'b0000, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0101, 4'b0000};

        model_reset();
        rst_n              = 1'b0;
        bus.irq_pins_i     = '1;
        bus.polarity_i     = '0;
        bus.edge_mode_i    = '0;
        bus.enable_i       = '1;
        bus.clear_i        = '0;
        @(negedge clk);

        // Reset held with pins high, then release and time the first assertion.
        repeat (3) cycle("reset_hold");
        chk("reset_level", 32'(bus.level_o), 32'd0);
        chk("reset_irq",   32'(bus.irq_o),   32'd0);
        rst_n = 1'b1;
        rise_edges(0, 1'b1, n);
        chk("reset_release_latency", n, 6);

        bus.irq_pins_i = '0;
        repeat (10) cycle("settle");

        // Glitch rejection on line 0.
        bus.irq_pins_i[0] = 1'b1;
        repeat (3) cycle("glitch3");
        bus.irq_pins_i[0] = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            cycle("glitch3_tail");
            if (bus.irq_o[0]) seen = 1'b1;
        end
        chk("glitch3_rejected", 32'(seen), 32'd0);

        cnt = 0;
        bus.irq_pins_i[0] = 1'b1;
        repeat (4) begin
            cycle("glitch4");
            if (bus.level_o[0]) cnt++;
        end
        bus.irq_pins_i[0] = 1'b0;
        repeat (14) begin
            cycle("glitch4_tail");
            if (bus.level_o[0]) cnt++;
        end
        chk("pulse4_level_cycles", cnt, 4);

        // Edge-mode latch and clear on line 1.
        bus.edge_mode_i = 4'b0010;
        pulse_pin(1, 10);
        chk("edge_latch_hold", 32'(bus.irq_o[1]), 32'd1);
        bus.clear_i[1] = 1'b1;
        cycle("edge_clear");
        bus.clear_i[1] = 1'b0;
        chk("edge_clear_next", 32'(bus.irq_o[1]), 32'd0);
        pulse_pin(1, 10);
        chk("edge_relatch", 32'(bus.irq_o[1]), 32'd1);

        // Clear coincident with the rise event: set wins.
        bus.clear_i[1] = 1'b1;
        cycle("pre_clear");
        bus.clear_i[1] = 1'b0;
        bus.irq_pins_i[1] = 1'b1;
        repeat (5) cycle("set_vs_clear_wait");
        chk("set_vs_clear_before", 32'(bus.irq_o[1]), 32'd0);
        bus.clear_i[1] = 1'b1;
        cycle("set_vs_clear_edge");
        bus.clear_i[1] = 1'b0;
        chk("set_vs_clear_wins", 32'(bus.irq_o[1]), 32'd1);
        bus.irq_pins_i[1] = 1'b0;
        repeat (8) cycle("set_vs_clear_tail");

        // Active-low polarity on line 2.
        bus.polarity_i[2] = 1'b1;
        bus.irq_pins_i[2] = 1'b1;
        repeat (8) cycle("pol_idle");
        chk("pol_idle_irq", 32'(bus.irq_o[2]), 32'd0);
        bus.irq_pins_i[2] = 1'b0;
        repeat (8) cycle("pol_active");
        chk("pol_active_irq", 32'(bus.irq_o[2]), 32'd1);
        bus.polarity_i[2] = 1'b0;
        repeat (8) cycle("pol_restore");

        // Enable handling on line 3 (edge mode).
        bus.edge_mode_i = 4'b1010;
        bus.enable_i    = 4'b0111;
        pulse_pin(3, 10);
        chk("disabled_no_pending", 32'(bus.irq_o[3]), 32'd0);
        bus.enable_i = 4'b1111;
        repeat (2) cycle("enable_after");
        chk("enable_no_late_pending", 32'(bus.irq_o[3]), 32'd0);
        pulse_pin(3, 10);
        chk("enabled_latch", 32'(bus.irq_o[3]), 32'd1);
        bus.enable_i = 4'b0111;
        cycle("disable_pending");
        chk("disable_drops_irq", 32'(bus.irq_o[3]), 32'd0);
        bus.enable_i = 4'b1111;

        // Asynchronous reset mid-filter (line 0) with a pending line (line 1).
        chk("pre_reset_pending", 32'(bus.irq_o[1]), 32'd1);
        bus.irq_pins_i[0] = 1'b1;
        repeat (4) cycle("mid_filter");
        chk("mid_filter_not_yet", 32'(bus.level_o[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_irq",   32'(bus.irq_o),   32'd0);
        chk("async_reset_level", 32'(bus.level_o), 32'd0);
        @(negedge clk);
        repeat (2) cycle("mid_reset_hold");
        rst_n = 1'b1;
        rise_edges(0, 1'b0, n);
        chk("filter_restart_latency", n, 6);

        // Table-driven configurations from a clean reset.
        rst_n           = 1'b0;
        bus.irq_pins_i  = '0;
        bus.polarity_i  = '0;
        bus.edge_mode_i = '0;
        bus.enable_i    = '0;
        bus.clear_i     = '0;
        repeat (3) cycle("tbl_reset");
        rst_n = 1'b1;
        repeat (10) cycle("tbl_settle");
        for (int i = 0; i < 8; i++) begin
            bus.irq_pins_i  = tbl[i].pins;
            bus.polarity_i  = tbl[i].pol;
            bus.edge_mode_i = tbl[i].edm;
            bus.enable_i    = tbl[i].en;
            bus.clear_i     = tbl[i].clr;
            repeat (tbl[i].hold) cycle("tbl_step");
            chk($sformatf("tbl%0d_level", i), 32'(bus.level_o), 32'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_irq", i),   32'(bus.irq_o),   32'(tbl[i].exp_irq));
        end
        bus.clear_i = '0;

        // Randomised pins, clears and configuration against the reference model.
        for (int k = 0; k < 1000; k++) begin
            if (k % 64 == 0) begin
                bus.polarity_i  = N'($urandom);
                bus.edge_mode_i = N'($urandom);
                bus.enable_i    = N'($urandom) | N'($urandom);
            end
            for (int l = 0; l < N; l++) begin
                if ($urandom_range(4) == 0) bus.irq_pins_i[l] = ~bus.irq_pins_i[l];
            end
            bus.clear_i = N'($urandom) & N'($urandom) & N'($urandom);
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
